// File: rtl/fire_ctrl_pkg.sv
// Shared definitions for the fire controller: state codes, firing-mode codes
// and constant-width helpers used to size counters from parameters.
package fire_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'b000,
    ST_SHOOT_SINGLE = 3'b001,
    ST_SHOOT_AUTO   = 3'b010,
    ST_RELOAD       = 3'b011,
    ST_OVERHEAT     = 3'b100,
    ST_DOWNFALL     = 3'b101,
    ST_SHOOT_BURST  = 3'b110
  } fc_state_e;

  // Code 11 is reserved and behaves as single shot.
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_BURST  = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_RSVD   = 2'b11
  } fc_mode_e;

  function automatic int fc_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fire_interval_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
// One instance serves shot spacing, reload time and cooldown.
module fire_interval_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/multi_mode_fire_ctrl.sv
// Fire controller: single/burst/auto shooting with magazine accounting,
// reload, overheat cooldown and terminal DOWNFALL state cleared only by reboot.
module multi_mode_fire_ctrl
  import fire_ctrl_pkg::*;
#(
  parameter int MAG_SIZE      = 25,
  parameter int MAG_COUNT     = 3,
  parameter int BURST_LEN     = 3,
  parameter int SHOT_PERIOD   = 10,
  parameter int RELOAD_CYCLES = 50,
  parameter int COOL_CYCLES   = 100,
  parameter int CRIT_THRESH   = 2,
  localparam int BW = fc_clog2(MAG_SIZE + 1),
  localparam int MW = fc_max(fc_clog2(MAG_COUNT + 1), 1)
) (
  input  logic          sysclk,
  input  logic          reboot,
  input  logic          target_locked,
  input  logic          is_enemy,
  input  logic          fire_command,
  input  logic          overheat_sensor,
  input  logic [1:0]    firing_mode,
  output logic [2:0]    current_state,
  output logic          fire_trigger,
  output logic          criticality_alert,
  output logic [BW-1:0] bullets_left,
  output logic [MW-1:0] magazines_left
);

  localparam int TW = fc_clog2(fc_max(fc_max(SHOT_PERIOD, RELOAD_CYCLES), COOL_CYCLES));
  localparam int CW = fc_clog2(BURST_LEN + 1);
  localparam logic [TW-1:0] SHOT_VAL   = TW'(SHOT_PERIOD - 1);
  localparam logic [TW-1:0] RELOAD_VAL = TW'(RELOAD_CYCLES - 1);
  localparam logic [TW-1:0] COOL_VAL   = TW'(COOL_CYCLES - 1);
  localparam logic          INIT_CRIT  = (MAG_COUNT < CRIT_THRESH);

  fc_state_e     r_state, w_next;
  logic          r_trig, r_crit;
  logic [BW-1:0] r_bullets;
  logic [MW-1:0] r_mags, w_mags_next;
  logic [CW-1:0] r_burst_cnt;
  logic          w_fire, w_refill, w_burst_start, w_burst_inc;
  logic          w_tmr_load, w_tmr_done, w_fire_ok, w_hostile;
  logic [TW-1:0] w_tmr_val;
  fc_state_e     w_empty_dest;

  fire_interval_timer #(.W(TW)) u_timer (
    .i_clk      (sysclk),
    .i_rst      (reboot),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign w_hostile    = target_locked & is_enemy;
  assign w_fire_ok    = w_hostile & fire_command;
  assign w_empty_dest = (r_mags != '0) ? ST_RELOAD : ST_DOWNFALL;
  assign w_mags_next  = (w_refill && r_mags != '0) ? r_mags - MW'(1) : r_mags;

  always_comb begin
    w_next        = r_state;
    w_fire        = 1'b0;
    w_refill      = 1'b0;
    w_burst_start = 1'b0;
    w_burst_inc   = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = SHOT_VAL;
    case (r_state)
      ST_IDLE: begin
        if (overheat_sensor) begin
          w_next = ST_OVERHEAT; w_tmr_load = 1'b1; w_tmr_val = COOL_VAL;
        end else if (r_bullets == '0) begin
          w_next = w_empty_dest; w_tmr_load = 1'b1; w_tmr_val = RELOAD_VAL;
        end else if (w_fire_ok) begin
          w_fire = 1'b1; w_tmr_load = 1'b1; w_burst_start = 1'b1;
          case (fc_mode_e'(firing_mode))
            MODE_BURST: w_next = ST_SHOOT_BURST;
            MODE_AUTO:  w_next = ST_SHOOT_AUTO;
            default:    w_next = ST_SHOOT_SINGLE;
          endcase
        end
      end
      ST_SHOOT_SINGLE, ST_SHOOT_AUTO, ST_SHOOT_BURST: begin
        if (overheat_sensor) begin
          w_next = ST_OVERHEAT; w_tmr_load = 1'b1; w_tmr_val = COOL_VAL;
        end else if (r_bullets == '0) begin
          w_next = w_empty_dest; w_tmr_load = 1'b1; w_tmr_val = RELOAD_VAL;
        end else if (r_state == ST_SHOOT_SINGLE) begin
          if (!fire_command) w_next = ST_IDLE;
        end else if (r_state == ST_SHOOT_AUTO) begin
          if (!w_fire_ok) w_next = ST_IDLE;
          else if (w_tmr_done) begin w_fire = 1'b1; w_tmr_load = 1'b1; end
        end else begin
          // Burst ignores fire_command release; only losing the target aborts it.
          if (!w_hostile || r_burst_cnt >= CW'(BURST_LEN)) w_next = ST_IDLE;
          else if (w_tmr_done) begin
            w_fire = 1'b1; w_tmr_load = 1'b1; w_burst_inc = 1'b1;
          end
        end
      end
      ST_RELOAD: begin
        if (w_tmr_done) begin w_next = ST_IDLE; w_refill = 1'b1; end
      end
      ST_OVERHEAT: begin
        if (w_tmr_done && !overheat_sensor) w_next = ST_IDLE;
      end
      ST_DOWNFALL: w_next = ST_DOWNFALL;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      r_state     <= ST_IDLE;
      r_trig      <= 1'b0;
      r_bullets   <= BW'(MAG_SIZE);
      r_mags      <= MW'(MAG_COUNT);
      r_crit      <= INIT_CRIT;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_trig  <= w_fire;
      r_mags  <= w_mags_next;
      r_crit  <= (int'(w_mags_next) < CRIT_THRESH);
      if (w_refill) r_bullets <= BW'(MAG_SIZE);
      else if (w_fire && r_bullets != '0) r_bullets <= r_bullets - BW'(1);
      if (w_burst_start) r_burst_cnt <= CW'(1);
      else if (w_burst_inc) r_burst_cnt <= r_burst_cnt + CW'(1);
    end
  end

  assign current_state     = r_state;
  assign fire_trigger      = r_trig;
  assign criticality_alert = r_crit;
  assign bullets_left      = r_bullets;
  assign magazines_left    = r_mags;

endmodule
